// File: rtl/approx_mul_err_monitor_pkg.sv
// approx_err_pkg: shared defaults, derived widths and FSM state encoding for
// the approximate-multiplier error monitor.
package approx_err_pkg;

  localparam int unsigned W_DEF      = 8;
  localparam int unsigned N_LOG2_DEF = 8;

  // Derived widths for the default operand width
  localparam int unsigned PW  = 2 * W_DEF;      // product
  localparam int unsigned EW  = 2 * W_DEF + 1;  // signed error
  localparam int unsigned SQW = 4 * W_DEF;      // squared error

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/approx_mul_err_monitor_if.sv
// approx_mul_err_monitor_if: sample stream in, one result record per window out.
//  start/in_*/approx_p : window start pulse and sample handshake (master -> slave)
//  in_ready            : sample accepted when in_valid & in_ready
//  res_*               : result record handshake and statistics (slave -> master)
interface approx_mul_err_monitor_if
  import approx_err_pkg::*;
#(
  parameter int unsigned W      = W_DEF,
  parameter int unsigned N_LOG2 = N_LOG2_DEF
);

  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0]          in_a;
  logic [W-1:0]          in_b;
  logic [2*W-1:0]        approx_p;
  logic                  res_valid;
  logic                  res_ready;
  logic [2*W+N_LOG2-1:0] abs_sum;
  logic [4*W+N_LOG2-1:0] sq_sum;
  logic [2*W-1:0]        max_err;
  logic [N_LOG2:0]       mis_cnt;

  modport master (
    output start, in_valid, in_a, in_b, approx_p, res_ready,
    input  in_ready, res_valid, abs_sum, sq_sum, max_err, mis_cnt
  );

  modport slave (
    input  start, in_valid, in_a, in_b, approx_p, res_ready,
    output in_ready, res_valid, abs_sum, sq_sum, max_err, mis_cnt
  );

endinterface

// File: rtl/approx_mul_err_monitor_err_sq_stage.sv
// err_sq_stage: combinational magnitude and square of one signed error sample.
//  err     : signed error exact-approx (2W+1 bits)
//  abs_err : |err| (2W bits)
//  sq_err  : err*err (4W bits)
module err_sq_stage
  import approx_err_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic signed [2*W:0]   err,
  output logic        [2*W-1:0] abs_err,
  output logic        [4*W-1:0] sq_err
);

  localparam int unsigned PROD_W = 2 * W;
  localparam int unsigned SQ_W   = 4 * W;

  // |e| always fits 2W bits since both products are 2W-bit unsigned
  always_comb begin
    abs_err = err[2*W] ? PROD_W'(-err) : PROD_W'(err);
    sq_err  = SQ_W'(abs_err) * SQ_W'(abs_err);
  end

endmodule

// File: rtl/approx_mul_err_monitor.sv
// approx_mul_err_monitor: accumulates |e|, e^2, max |e| and mismatch count of
// an approximate multiplier over a window of 2**N_LOG2 accepted samples.
//  clk, rst : rising-edge clock, async active-high reset
//  bus      : slave side of approx_mul_err_monitor_if (samples in, results out)
module approx_mul_err_monitor
  import approx_err_pkg::*;
#(
  parameter int unsigned W      = W_DEF,
  parameter int unsigned N_LOG2 = N_LOG2_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  approx_mul_err_monitor_if.slave   bus
);

  localparam int unsigned PROD_W = 2 * W;
  localparam int unsigned ERR_W  = PROD_W + 1;
  localparam int unsigned SQ_W   = 4 * W;
  localparam int unsigned CNT_W  = N_LOG2 + 1;
  localparam int unsigned ABS_W  = PROD_W + N_LOG2;
  localparam int unsigned SQS_W  = SQ_W + N_LOG2;
  localparam logic [CNT_W-1:0] WIN = CNT_W'(1) << N_LOG2;

  state_t state_q, state_d;

  logic [CNT_W-1:0]         cnt_q;
  logic                     s1_valid_q;
  logic signed [ERR_W-1:0]  s1_err_q;
  logic                     res_valid_q;
  logic [ABS_W-1:0]         abs_sum_q;
  logic [SQS_W-1:0]         sq_sum_q;
  logic [PROD_W-1:0]        max_err_q;
  logic [CNT_W-1:0]         mis_cnt_q;

  logic                     accept_c;
  logic                     last_c;
  logic                     win_start_c;
  logic [PROD_W-1:0]        exact_c;
  logic signed [ERR_W-1:0]  err_c;
  logic [PROD_W-1:0]        abs_c;
  logic [SQ_W-1:0]          sq_c;

  // in_ready closes as soon as the window count is reached
  assign bus.in_ready = (state_q == ST_RUN) && (cnt_q != WIN);
  assign accept_c     = bus.in_valid && bus.in_ready;
  assign last_c       = accept_c && (cnt_q == WIN - CNT_W'(1));
  assign win_start_c  = (state_q == ST_IDLE) && (state_d == ST_RUN);

  // Exact product and signed error of the incoming sample
  assign exact_c = PROD_W'(bus.in_a) * PROD_W'(bus.in_b);
  assign err_c   = $signed({1'b0, exact_c}) - $signed({1'b0, bus.approx_p});

  err_sq_stage #(.W(W)) u_err_sq (
    .err     (s1_err_q),
    .abs_err (abs_c),
    .sq_err  (sq_c)
  );

  // Next-state logic; DRAIN waits for the last sample to leave S1
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_RUN;
      ST_RUN:   if (last_c) state_d = ST_DRAIN;
      ST_DRAIN: if (!s1_valid_q) state_d = ST_DONE;
      ST_DONE:  if (res_valid_q && bus.res_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // S1 capture, S2 accumulate, result flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_err_q    <= '0;
      res_valid_q <= 1'b0;
      abs_sum_q   <= '0;
      sq_sum_q    <= '0;
      max_err_q   <= '0;
      mis_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= accept_c;
      // approx_p is only looked at on accepted cycles
      if (accept_c) s1_err_q <= err_c;
      res_valid_q <= (state_d == ST_DONE);
      if (win_start_c) begin
        cnt_q     <= '0;
        abs_sum_q <= '0;
        sq_sum_q  <= '0;
        max_err_q <= '0;
        mis_cnt_q <= '0;
      end else begin
        if (accept_c) cnt_q <= cnt_q + CNT_W'(1);
        if (s1_valid_q) begin
          abs_sum_q <= abs_sum_q + ABS_W'(abs_c);
          sq_sum_q  <= sq_sum_q + SQS_W'(sq_c);
          if (abs_c > max_err_q) max_err_q <= abs_c;
          if (s1_err_q != '0) mis_cnt_q <= mis_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.abs_sum   = abs_sum_q;
  assign bus.sq_sum    = sq_sum_q;
  assign bus.max_err   = max_err_q;
  assign bus.mis_cnt   = mis_cnt_q;

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
module tb_approx_mul_err_monitor;

  localparam int unsigned TW  = 8;
  localparam int unsigned TN  = 8;
  localparam int          WIN = 1 << TN;

  typedef struct {
    longint abs_s;
    longint sq_s;
    longint mx;
    longint mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  approx_mul_err_monitor_if #(.W(TW), .N_LOG2(TN)) bus ();

  approx_mul_err_monitor #(.W(TW), .N_LOG2(TN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  exp_t   exp_q[$];
  int     acc_cnt = 0;
  longint last_acc = 0;
  bit     prev_rv = 1'b0;
  logic [88:0] snap;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: counts accepts, checks latency, stability and result records
  always @(negedge clk) begin
    if (rst) begin
      acc_cnt = 0;
      prev_rv = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        acc_cnt++;
        last_acc = cyc;
      end
      if (bus.res_valid && !prev_rv)
        check("latency", cyc - last_acc, 3);
      if (bus.res_valid && prev_rv)
        check("stable", (snap != {bus.abs_sum, bus.sq_sum, bus.max_err, bus.mis_cnt}) ? 1 : 0, 0);
      if (bus.res_valid)
        snap = {bus.abs_sum, bus.sq_sum, bus.max_err, bus.mis_cnt};
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("abs_sum", bus.abs_sum, e.abs_s);
          check("sq_sum",  bus.sq_sum,  e.sq_s);
          check("max_err", bus.max_err, e.mx);
          check("mis_cnt", bus.mis_cnt, e.mis);
          check("accepts", acc_cnt, WIN);
        end
        acc_cnt = 0;
      end
      prev_rv = bus.res_valid;
    end
  end

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p, input bit st);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.approx_p = p;
    bus.start = st;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    bus.in_a = 8'($urandom);
    bus.in_b = 8'($urandom);
    bus.approx_p = 16'($urandom);
  endtask

  task automatic wait_result(input int hold, input bit ds, input exp_t e);
    bit ok;
    ok = 1'b0;
    bus.res_ready = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("result_timeout", 0, 1);
    @(posedge clk); #1;
    if (ds) begin
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b1;
    bus.start = ds;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    bus.start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_not_ready", bus.in_ready, 0);
    end
    check("hold_abs_sum", bus.abs_sum, e.abs_s);
    check("hold_mis_cnt", bus.mis_cnt, e.mis);
    @(posedge clk); #1;
  endtask

  // mode: 0 exact, 1 exact+1, 2 one worst-case sample, 3 random approx_p
  task automatic run_window(input int mode, input bit gap, input int hold,
                            input bit mid_start, input bit extra, input bit ds);
    exp_t e;
    int big;
    e = '{0, 0, 0, 0};
    big = $urandom_range(WIN - 1, 0);
    do_start();
    for (int i = 0; i < WIN; i++) begin
      int a, b, p;
      longint ae;
      a = $urandom_range(255, 0);
      b = $urandom_range(255, 0);
      case (mode)
        0: p = a * b;
        1: p = a * b + 1;
        2: begin
          if (i == big) begin
            a = 255; b = 255; p = 0;
          end else p = a * b;
        end
        default: p = $urandom_range(65535, 0);
      endcase
      ae = longint'(a * b) - longint'(p);
      if (ae < 0) ae = -ae;
      e.abs_s += ae;
      e.sq_s  += ae * ae;
      if (ae > e.mx) e.mx = ae;
      if (ae != 0) e.mis++;
      send(8'(a), 8'(b), 16'(p), mid_start && (i == 50));
      if (gap) begin
        @(posedge clk); #1;
      end
    end
    exp_q.push_back(e);
    if (extra) begin
      bus.in_valid = 1'b1;
      repeat (5) begin
        @(negedge clk);
        check("no_extra_accept", bus.in_ready, 0);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
    wait_result(hold, ds, e);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.approx_p = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  bus.in_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_abs_sum",   bus.abs_sum, 0);
    check("rst_sq_sum",    bus.sq_sum, 0);
    check("rst_max_err",   bus.max_err, 0);
    check("rst_mis_cnt",   bus.mis_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_window(0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_window(1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_window(2, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_window(3, 1'b1, 10, 1'b0, 1'b1, 1'b0);
    run_window(3, 1'b0, 4, 1'b1, 1'b0, 1'b1);

    // Abort a window at sample 100
    do_start();
    for (int i = 0; i < 100; i++)
      send(8'($urandom), 8'($urandom), 16'($urandom), 1'b0);
    rst = 1'b1;
    #2;
    check("abort_in_ready",  bus.in_ready, 0);
    check("abort_res_valid", bus.res_valid, 0);
    check("abort_abs_sum",   bus.abs_sum, 0);
    check("abort_sq_sum",    bus.sq_sum, 0);
    check("abort_max_err",   bus.max_err, 0);
    check("abort_mis_cnt",   bus.mis_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_result", bus.res_valid, 0);
    end
    @(posedge clk); #1;

    run_window(3, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_window(1, 1'b1, 2, 1'b0, 1'b1, 1'b0);

    repeat (5) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
